unpool_upsample: RTL
====================

UNPOOL_UPSAMPLE -- requirements
Module: unpool_upsample

Interface
REQ-001 SHALL have parameter W, default 4: pooled (input) row width in bits, W >= 2.
REQ-002 SHALL have parameter H, default 4: pooled (input) rows per frame, H >= 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, 1 bit: one pooled binary pixel, raster order.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-010 SHALL have port out_data, output, 1 bit: one upsampled binary pixel, raster order.
REQ-011 SHALL have port out_row_end, output, 1 bit: qualifies the last pixel of an output row (2W pixels).
REQ-012 SHALL have port out_frame_end, output, 1 bit: qualifies the last pixel of an output frame (2W x 2H pixels).

Function
REQ-013 SHALL perform nearest-neighbour 2x2 unpooling: each input pixel (r,c) is output at (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
REQ-014 SHALL transfer input only on in_valid && in_ready and output only on out_valid && out_ready.
REQ-015 SHALL hold out_valid, out_data, out_row_end and out_frame_end stable while out_valid && !out_ready.
REQ-016 SHALL keep state: FSM {PASS1, PASS2}, column counter col (0..W-1), phase bit ph (0/1), row counter row (0..H-1), holding bit hold with flag have, and a W-bit row buffer buf.
REQ-017 PASS1: in_ready = !have; on acceptance hold <= in_data, buf[col] <= in_data, have <= 1.
REQ-018 PASS1: out_valid = have, out_data = hold; first output exactly one cycle after input acceptance.
REQ-019 PASS1 output handshake: if ph=0 then ph <= 1; else ph <= 0, have <= 0, and either col <= col+1 or, if col = W-1, col <= 0 and state <= PASS2.
REQ-020 PASS2: in_ready = 0; out_valid = 1; out_data = buf[col].
REQ-021 PASS2 output handshake: if ph=0 then ph <= 1; else ph <= 0, and either col <= col+1 or, if col = W-1, col <= 0 and state <= PASS1, with row <= row+1, or row <= 0 when row = H-1.
REQ-022 out_row_end SHALL equal out_valid && ph=1 && col=W-1, in either state.
REQ-023 out_frame_end SHALL equal out_row_end && state=PASS2 && row=H-1.
REQ-024 Each output pixel SHALL occupy at least one cycle; PASS1 requires at least 3 cycles per input pixel (accept, copy 0, copy 1); PASS2 SHALL sustain 1 pixel/cycle with out_ready held high.
REQ-025 in_valid while in_ready=0 SHALL be ignored; the input is not consumed and the block has no side effects.
REQ-026 Deasserting out_ready mid-row SHALL stall all counters; no pixel is dropped or duplicated beyond REQ-013.
REQ-027 in_data SHALL be forwarded without alteration; X/Z propagation behaviour is not specified.

Reset
REQ-028 rst=1 at a clock edge SHALL set state=PASS1, col=0, ph=0, row=0, have=0, hold=0.
REQ-029 During and after reset SHALL drive out_valid=0, out_data=0, out_row_end=0, out_frame_end=0, and in_ready=1 from the first cycle after reset.
REQ-030 buf SHALL NOT be reset; it is fully rewritten in PASS1 before PASS2 reads it.
REQ-031 Reset asserted mid-row or mid-frame SHALL abandon the partial frame; the next accepted input is pixel (0,0) of a new frame.

Verification
REQ-032 W=4,H=1, input 1,0,1,1, out_ready=1 -> output rows 11001111 then 11001111; out_row_end on pixels 8 and 16; out_frame_end only on pixel 16.
REQ-033 W=4,H=2, inputs 1000 then 0001 -> four output rows 11000000, 11000000, 00000011, 00000011; out_frame_end on pixel 32 only; row wraps to 0.
REQ-034 Random out_ready (50% duty), random in_valid gaps over 3 frames W=4,H=2 -> output stream identical to the golden model; outputs stable during every stall.
REQ-035 in_valid=1 held continuously during PASS2 -> in_ready=0 throughout, no input consumed, and the first PASS1 accept takes the next pooled pixel.
REQ-036 Assert rst for 1 cycle after the 3rd output pixel of row 0 -> out_valid=0 next cycle, in_ready=1, and new input 0,1,1,0 produces 00111100 twice.

Source files
------------

// File: rtl/unpool_upsample.sv
// 2x2 nearest-neighbour unpooling of a binary raster stream.
// Each pooled row is emitted twice: once live from the input, once from a row buffer.
module unpool_upsample #(
  parameter int W = 4,
  parameter int H = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_data,
  output logic out_row_end,
  output logic out_frame_end
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  typedef enum logic {PASS1, PASS2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic            ph_q, ph_d;
  logic [RW-1:0]   row_q, row_d;
  logic            hold_q, hold_d;
  logic            have_q, have_d;
  logic [W-1:0]    rbuf_q, rbuf_d;

  logic acc;
  logic fire;
  logic col_end;

  always_comb begin
    in_ready      = (state_q == PASS1) && !have_q;
    out_valid     = (state_q == PASS2) || have_q;
    out_data      = (state_q == PASS2) ? rbuf_q[col_q] : hold_q;
    col_end       = (col_q == COL_LAST);
    out_row_end   = out_valid && ph_q && col_end;
    out_frame_end = out_row_end && (state_q == PASS2) && (row_q == ROW_LAST);
    acc           = in_valid && in_ready;
    fire          = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    ph_d    = ph_q;
    row_d   = row_q;
    hold_d  = hold_q;
    have_d  = have_q;
    rbuf_d  = rbuf_q;
    if (acc) begin
      hold_d        = in_data;
      rbuf_d[col_q] = in_data;
      have_d        = 1'b1;
    end
    // acc and fire never coincide: PASS1 accepts only while nothing is held
    if (fire) begin
      if (!ph_q) begin
        ph_d = 1'b1;
      end else begin
        ph_d = 1'b0;
        if (state_q == PASS1) have_d = 1'b0;
        if (col_end) begin
          col_d = '0;
          if (state_q == PASS1) begin
            state_d = PASS2;
          end else begin
            state_d = PASS1;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS1;
      col_q   <= '0;
      ph_q    <= 1'b0;
      row_q   <= '0;
      hold_q  <= 1'b0;
      have_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      ph_q    <= ph_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      have_q  <= have_d;
    end
  end

  // Row buffer is always rewritten in PASS1 before PASS2 reads it
  always_ff @(posedge clk) begin
    rbuf_q <= rbuf_d;
  end

endmodule
